// File: rtl/cuckoo_hash_table.sv
// Two-table cuckoo hash key store with a bounded kick/evict insert loop.
// One command in flight; a single-cycle response pulse per command.
module cuckoo_hash_table #(
  parameter int KEY_W     = 32,
  parameter int IDX_W     = 4,
  parameter int MAX_KICKS = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_code,
  input  logic [KEY_W-1:0]   op_key,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [1:0]         resp_status,
  output logic               resp_table,
  output logic [IDX_W-1:0]   resp_index,
  output logic [KEY_W-1:0]   resp_key,
  output logic [IDX_W+1:0]   occupancy
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int KCNT_W = (MAX_KICKS < 1) ? 1 : $clog2(MAX_KICKS + 1);

  localparam logic [KCNT_W-1:0] KICK_LIMIT = KCNT_W'(MAX_KICKS);
  localparam logic [IDX_W+1:0]  OCC_FULL   = (IDX_W + 2)'(2 * DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_PLACE1 = 3'd2;
  localparam logic [2:0] S_PLACE2 = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DUP  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  // Storage: key data plus a valid bit per slot in each table
  logic [KEY_W-1:0] t1_key_q [DEPTH];
  logic [KEY_W-1:0] t2_key_q [DEPTH];
  logic [DEPTH-1:0] t1_vld_q, t1_vld_d;
  logic [DEPTH-1:0] t2_vld_q, t2_vld_d;

  // Control state
  logic [2:0]        state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  cur_q, cur_d;
  logic [KCNT_W-1:0] kicks_q, kicks_d;
  logic [IDX_W+1:0]  occ_q, occ_d;

  // Response registers, held between responses
  logic              resp_hit_q, resp_hit_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic              resp_table_q, resp_table_d;
  logic [IDX_W-1:0]  resp_index_q, resp_index_d;
  logic [KEY_W-1:0]  resp_key_q, resp_key_d;

  // Datapath strobes
  logic t1_we, t2_we;
  logic occ_inc, occ_dec;

  // Hash indices for the command key (CHECK) and the key being placed (PLACE)
  logic [IDX_W-1:0] chk_h1, chk_h2, cur_h1, cur_h2;
  logic             chk_hit1, chk_hit2;

  assign chk_h1   = key_q[IDX_W-1:0];
  assign chk_h2   = key_q[2*IDX_W-1:IDX_W];
  assign cur_h1   = cur_q[IDX_W-1:0];
  assign cur_h2   = cur_q[2*IDX_W-1:IDX_W];
  assign chk_hit1 = t1_vld_q[chk_h1] && (t1_key_q[chk_h1] == key_q);
  assign chk_hit2 = t2_vld_q[chk_h2] && (t2_key_q[chk_h2] == key_q);

  assign op_ready    = rst_n && (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_hit    = resp_hit_q;
  assign resp_status = resp_status_q;
  assign resp_table  = resp_table_q;
  assign resp_index  = resp_index_q;
  assign resp_key    = resp_key_q;
  assign occupancy   = occ_q;

  // Command sequencing: accept, probe both tables, then walk the kick loop
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    key_d         = key_q;
    cur_d         = cur_q;
    kicks_d       = kicks_q;
    resp_hit_d    = resp_hit_q;
    resp_status_d = resp_status_q;
    resp_table_d  = resp_table_q;
    resp_index_d  = resp_index_q;
    resp_key_d    = resp_key_q;
    t1_vld_d      = t1_vld_q;
    t2_vld_d      = t2_vld_q;
    t1_we         = 1'b0;
    t2_we         = 1'b0;
    occ_inc       = 1'b0;
    occ_dec       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d  = op_code;
          key_d   = op_key;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (code_q == OP_INSERT) begin
          if (chk_hit1 || chk_hit2) begin
            resp_hit_d    = 1'b1;
            resp_status_d = ST_DUP;
            resp_table_d  = !chk_hit1;
            resp_index_d  = chk_hit1 ? chk_h1 : chk_h2;
            resp_key_d    = key_q;
            state_d       = S_RESP;
          end else begin
            cur_d   = key_q;
            kicks_d = '0;
            state_d = S_PLACE1;
          end
        end else begin
          resp_hit_d    = chk_hit1 || chk_hit2;
          resp_status_d = ST_OK;
          resp_table_d  = !chk_hit1 && chk_hit2;
          resp_index_d  = (!chk_hit1 && chk_hit2) ? chk_h2 : chk_h1;
          resp_key_d    = key_q;
          if (code_q == OP_DELETE) begin
            if (chk_hit1) begin
              t1_vld_d[chk_h1] = 1'b0;
              occ_dec          = 1'b1;
            end else if (chk_hit2) begin
              t2_vld_d[chk_h2] = 1'b0;
              occ_dec          = 1'b1;
            end
          end
          state_d = S_RESP;
        end
      end

      S_PLACE1: begin
        resp_table_d = 1'b0;
        resp_index_d = cur_h1;
        resp_hit_d   = 1'b0;
        if (!t1_vld_q[cur_h1]) begin
          t1_we            = 1'b1;
          t1_vld_d[cur_h1] = 1'b1;
          occ_inc          = 1'b1;
          resp_status_d    = ST_OK;
          resp_key_d       = key_q;
          state_d          = S_RESP;
        end else if (kicks_q != KICK_LIMIT) begin
          t1_we   = 1'b1;
          cur_d   = t1_key_q[cur_h1];
          kicks_d = kicks_q + 1'b1;
          state_d = S_PLACE2;
        end else begin
          resp_status_d = ST_FAIL;
          resp_key_d    = cur_q;
          state_d       = S_RESP;
        end
      end

      S_PLACE2: begin
        resp_table_d = 1'b1;
        resp_index_d = cur_h2;
        resp_hit_d   = 1'b0;
        if (!t2_vld_q[cur_h2]) begin
          t2_we            = 1'b1;
          t2_vld_d[cur_h2] = 1'b1;
          occ_inc          = 1'b1;
          resp_status_d    = ST_OK;
          resp_key_d       = key_q;
          state_d          = S_RESP;
        end else if (kicks_q != KICK_LIMIT) begin
          t2_we   = 1'b1;
          cur_d   = t2_key_q[cur_h2];
          kicks_d = kicks_q + 1'b1;
          state_d = S_PLACE1;
        end else begin
          resp_status_d = ST_FAIL;
          resp_key_d    = cur_q;
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Occupancy saturates at both ends so it can never wrap
  always_comb begin
    occ_d = occ_q;
    if (occ_inc && (occ_q != OCC_FULL)) begin
      occ_d = occ_q + 1'b1;
    end else if (occ_dec && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Control, valid bits and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      code_q        <= '0;
      key_q         <= '0;
      cur_q         <= '0;
      kicks_q       <= '0;
      occ_q         <= '0;
      t1_vld_q      <= '0;
      t2_vld_q      <= '0;
      resp_hit_q    <= 1'b0;
      resp_status_q <= ST_OK;
      resp_table_q  <= 1'b0;
      resp_index_q  <= '0;
      resp_key_q    <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      key_q         <= key_d;
      cur_q         <= cur_d;
      kicks_q       <= kicks_d;
      occ_q         <= occ_d;
      t1_vld_q      <= t1_vld_d;
      t2_vld_q      <= t2_vld_d;
      resp_hit_q    <= resp_hit_d;
      resp_status_q <= resp_status_d;
      resp_table_q  <= resp_table_d;
      resp_index_q  <= resp_index_d;
      resp_key_q    <= resp_key_d;
    end
  end

  // Key data needs no reset; a slot is meaningful only while its valid bit is set
  always_ff @(posedge clk) begin
    if (t1_we) begin
      t1_key_q[cur_h1] <= cur_q;
    end
    if (t2_we) begin
      t2_key_q[cur_h2] <= cur_q;
    end
  end

endmodule

// File: tb/tb_cuckoo_hash_table.sv
// Directed bench for cuckoo_hash_table with a 4-slot-per-table configuration.
module tb_cuckoo_hash_table;

  localparam int KEY_W     = 32;
  localparam int IDX_W     = 2;
  localparam int MAX_KICKS = 4;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [KEY_W-1:0] op_key;
  logic             resp_valid;
  logic             resp_hit;
  logic [1:0]       resp_status;
  logic             resp_table;
  logic [IDX_W-1:0] resp_index;
  logic [KEY_W-1:0] resp_key;
  logic [IDX_W+1:0] occupancy;

  int n_checks;
  int n_fail;

  cuckoo_hash_table #(
    .KEY_W    (KEY_W),
    .IDX_W    (IDX_W),
    .MAX_KICKS(MAX_KICKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_key     (op_key),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_status(resp_status),
    .resp_table (resp_table),
    .resp_index (resp_index),
    .resp_key   (resp_key),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and count edges from the accept edge (counted as 1) to resp_valid
  task automatic do_op(input logic [1:0] code, input logic [KEY_W-1:0] key, output int lat);
    int waited;
    waited = 0;
    lat    = -1;
    while (!op_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!op_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL op_ready_timeout: op_ready=%0b required 1", op_ready);
      return;
    end
    op_valid = 1'b1;
    op_code  = code;
    op_key   = key;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL resp_timeout: key=%0h no resp_valid within %0d cycles", key, lat);
      lat = -1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int lat;
    rst_n    = 1'b0;
    op_valid = 1'b1;
    op_code  = OP_INSERT;
    op_key   = 32'h5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (op_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_op_ready[%0d]: got %0b required 0", i, op_ready); end
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %0b required 0", resp_valid); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_occupancy: got %0d required 0", occupancy); end
    n_checks++;
    if ({resp_hit, resp_status, resp_table, resp_index} !== 6'd0) begin
      n_fail++; $display("[TB] FAIL reset_resp_fields: got hit=%0b st=%0b tbl=%0b idx=%0d required all 0", resp_hit, resp_status, resp_table, resp_index);
    end
    n_checks++;
    if (resp_key !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_resp_key: got %0h required 0", resp_key); end
    op_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    n_checks++;
    if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_op_ready: got %0b required 1", op_ready); end
    do_op(OP_LOOKUP, 32'h5, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("[TB] FAIL lookup_miss_latency: got %0d required 2", lat); end
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL lookup_miss_hit: got %0b required 0", resp_hit); end
    n_checks++;
    if (resp_key !== 32'h5) begin n_fail++; $display("[TB] FAIL lookup_miss_key: got %0h required 5", resp_key); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL lookup_miss_occ: got %0d required 0", occupancy); end
  endtask

  task automatic test_insert();
    int lat;
    do_op(OP_INSERT, 32'h5, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL ins5_latency: got %0d required 3", lat); end
    n_checks++;
    if ({resp_hit, resp_status, resp_table, resp_index} !== {1'b0, 2'b00, 1'b0, 2'd1}) begin
      n_fail++; $display("[TB] FAIL ins5_fields: got hit=%0b st=%0b tbl=%0b idx=%0d required 0/00/0/1", resp_hit, resp_status, resp_table, resp_index);
    end
    n_checks++;
    if (occupancy !== 4'd1) begin n_fail++; $display("[TB] FAIL ins5_occ: got %0d required 1", occupancy); end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resp_pulse_width: resp_valid=%0b required 0", resp_valid); end
    n_checks++;
    if (resp_key !== 32'h5) begin n_fail++; $display("[TB] FAIL resp_key_hold: got %0h required 5", resp_key); end
    do_op(OP_INSERT, 32'h5, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("[TB] FAIL dup_latency: got %0d required 2", lat); end
    n_checks++;
    if ({resp_hit, resp_status, resp_table, resp_index} !== {1'b1, 2'b01, 1'b0, 2'd1}) begin
      n_fail++; $display("[TB] FAIL dup_fields: got hit=%0b st=%0b tbl=%0b idx=%0d required 1/01/0/1", resp_hit, resp_status, resp_table, resp_index);
    end
    n_checks++;
    if (occupancy !== 4'd1) begin n_fail++; $display("[TB] FAIL dup_occ: got %0d required 1", occupancy); end
  endtask

  task automatic test_kick();
    int lat;
    do_op(OP_INSERT, 32'h9, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("[TB] FAIL kick_latency: got %0d required 4", lat); end
    n_checks++;
    if ({resp_status, resp_table, resp_index} !== {2'b00, 1'b1, 2'd1}) begin
      n_fail++; $display("[TB] FAIL kick_fields: got st=%0b tbl=%0b idx=%0d required 00/1/1", resp_status, resp_table, resp_index);
    end
    n_checks++;
    if (resp_key !== 32'h9) begin n_fail++; $display("[TB] FAIL kick_key: got %0h required 9", resp_key); end
    n_checks++;
    if (occupancy !== 4'd2) begin n_fail++; $display("[TB] FAIL kick_occ: got %0d required 2", occupancy); end
    do_op(OP_LOOKUP, 32'h5, lat);
    n_checks++;
    if ({resp_hit, resp_table, resp_index} !== {1'b1, 1'b1, 2'd1}) begin
      n_fail++; $display("[TB] FAIL lookup5_after_kick: got hit=%0b tbl=%0b idx=%0d required 1/1/1", resp_hit, resp_table, resp_index);
    end
    do_op(OP_LOOKUP, 32'h9, lat);
    n_checks++;
    if ({resp_hit, resp_table, resp_index} !== {1'b1, 1'b0, 2'd1}) begin
      n_fail++; $display("[TB] FAIL lookup9_after_kick: got hit=%0b tbl=%0b idx=%0d required 1/0/1", resp_hit, resp_table, resp_index);
    end
  endtask

  task automatic test_kick_fail();
    int lat;
    do_reset();
    do_op(OP_INSERT, 32'h00, lat);
    n_checks++;
    if ({resp_status, resp_table, resp_index} !== {2'b00, 1'b0, 2'd0}) begin
      n_fail++; $display("[TB] FAIL ins00_fields: got st=%0b tbl=%0b idx=%0d required 00/0/0", resp_status, resp_table, resp_index);
    end
    do_op(OP_INSERT, 32'h10, lat);
    n_checks++;
    if (lat !== 4 || resp_table !== 1'b1 || resp_index !== 2'd0) begin
      n_fail++; $display("[TB] FAIL ins10: got lat=%0d tbl=%0b idx=%0d required 4/1/0", lat, resp_table, resp_index);
    end
    do_op(OP_INSERT, 32'h20, lat);
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("[TB] FAIL fail_latency: got %0d required 7", lat); end
    n_checks++;
    if (resp_status !== 2'b10 || resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fail_status: got st=%0b hit=%0b required 10/0", resp_status, resp_hit); end
    n_checks++;
    if (resp_key !== 32'h10) begin n_fail++; $display("[TB] FAIL fail_homeless_key: got %0h required 10", resp_key); end
    n_checks++;
    if (occupancy !== 4'd2) begin n_fail++; $display("[TB] FAIL fail_occ: got %0d required 2", occupancy); end
    do_op(OP_LOOKUP, 32'h00, lat);
    n_checks++;
    if ({resp_hit, resp_table, resp_index} !== {1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("[TB] FAIL fail_t1_slot: got hit=%0b tbl=%0b idx=%0d required 1/0/0", resp_hit, resp_table, resp_index);
    end
    do_op(OP_LOOKUP, 32'h20, lat);
    n_checks++;
    if ({resp_hit, resp_table, resp_index} !== {1'b1, 1'b1, 2'd0}) begin
      n_fail++; $display("[TB] FAIL fail_t2_slot: got hit=%0b tbl=%0b idx=%0d required 1/1/0", resp_hit, resp_table, resp_index);
    end
    do_op(OP_LOOKUP, 32'h10, lat);
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL homeless_absent: got hit=%0b required 0", resp_hit); end
  endtask

  task automatic test_delete();
    int lat;
    int pulses;
    do_op(OP_INSERT, 32'h9, lat);
    n_checks++;
    if (lat !== 3 || occupancy !== 4'd3) begin n_fail++; $display("[TB] FAIL ins9: got lat=%0d occ=%0d required 3/3", lat, occupancy); end
    do_op(OP_DELETE, 32'h9, lat);
    n_checks++;
    if (lat !== 2 || resp_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL del9_hit: got lat=%0d hit=%0b required 2/1", lat, resp_hit); end
    n_checks++;
    if (resp_table !== 1'b0 || resp_index !== 2'd1) begin n_fail++; $display("[TB] FAIL del9_loc: got tbl=%0b idx=%0d required 0/1", resp_table, resp_index); end
    n_checks++;
    if (occupancy !== 4'd2) begin n_fail++; $display("[TB] FAIL del9_occ: got %0d required 2", occupancy); end
    do_op(OP_DELETE, 32'h9, lat);
    n_checks++;
    if (resp_hit !== 1'b0 || occupancy !== 4'd2) begin n_fail++; $display("[TB] FAIL del9_again: got hit=%0b occ=%0d required 0/2", resp_hit, occupancy); end
    do_op(OP_LOOKUP, 32'h9, lat);
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL lookup9_deleted: got hit=%0b required 0", resp_hit); end
    // Busy: a delete of 0x00 is offered while an insert of 0x5 is in flight
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_INSERT; op_key = 32'h5;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_DELETE; op_key = 32'h00;
    n_checks++;
    if (op_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_op_ready: got %0b required 0", op_ready); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_key !== 32'h5 || resp_status !== 2'b00) begin
      n_fail++; $display("[TB] FAIL busy_insert_resp: got valid=%0b key=%0h st=%0b required 1/5/00", resp_valid, resp_key, resp_status);
    end
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("[TB] FAIL busy_extra_resp: got %0d pulses required 0", pulses); end
    do_op(OP_LOOKUP, 32'h00, lat);
    n_checks++;
    if (resp_hit !== 1'b1 || occupancy !== 4'd3) begin n_fail++; $display("[TB] FAIL busy_ignored: got hit=%0b occ=%0d required 1/3", resp_hit, occupancy); end
  endtask

  task automatic test_reset_mid_kick();
    int lat;
    int pulses;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_INSERT; op_key = 32'h10;
    @(posedge clk); #1;
    op_valid = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (op_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_op_ready: got %0b required 1", op_ready); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_occ: got %0d required 0", occupancy); end
    n_checks++;
    if (resp_key !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_resp_key: got %0h required 0", resp_key); end
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("[TB] FAIL midreset_resp_seen: got %0d pulses required 0", pulses); end
    do_op(OP_LOOKUP, 32'h00, lat);
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_lookup00: got hit=%0b required 0", resp_hit); end
    do_op(OP_LOOKUP, 32'h10, lat);
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_lookup10: got hit=%0b required 0", resp_hit); end
    do_op(OP_LOOKUP, 32'h20, lat);
    n_checks++;
    if (resp_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_lookup20: got hit=%0b required 0", resp_hit); end
    do_op(OP_LOOKUP, 32'h5, lat);
    n_checks++;
    if (resp_hit !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_lookup5: got hit=%0b occ=%0d required 0/0", resp_hit, occupancy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = OP_LOOKUP;
    op_key   = '0;
    $display("[TB] starting cuckoo_hash_table directed tests");
    test_reset();
    test_insert();
    test_kick();
    test_kick_fail();
    test_delete();
    test_reset_mid_kick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cuckoo_hash_table.md
Name: cuckoo_hash_table

Overview:
- Parametrised two-table cuckoo hash key store. Supports insert, lookup and delete of fixed-width keys.
- Insert uses a bounded kick/evict loop and reports the homeless key on failure, so upstream logic can stash it.
- Sits behind the key-value front end as the index engine: one operation in flight, valid/ready command side, single-cycle response pulse.

Parameters:
- KEY_W, 32: key width in bits; must satisfy KEY_W >= 2*IDX_W.
- IDX_W, 4: index width; each table holds DEPTH = 2^IDX_W slots.
- MAX_KICKS, 20: maximum evictions allowed per insert before it is declared failed.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: synchronous, active-low reset.
- op_valid, input, 1: command valid.
- op_ready, output, 1: block can accept a command.
- op_code, input, 2: 00 lookup, 01 insert, 10 delete, 11 reserved (treated as lookup).
- op_key, input, KEY_W: command key.
- resp_valid, output, 1: one-cycle response pulse.
- resp_hit, output, 1: key found (lookup/delete) or already present (insert).
- resp_status, output, 2: 00 OK, 01 DUP (insert of present key), 10 FAIL (kick limit reached).
- resp_table, output, 1: 0 = T1, 1 = T2; slot of hit or of last write.
- resp_index, output, IDX_W: slot index matching resp_table.
- resp_key, output, KEY_W: echoed key; on FAIL, the homeless key.
- occupancy, output, IDX_W+2: count of valid slots, range 0..2*DEPTH.

Behaviour:
- Storage:
  - T1 and T2, each DEPTH x (KEY_W data + valid bit), held in flops with combinational read.
  - h1(k) = k[IDX_W-1:0]; h2(k) = k[2*IDX_W-1:IDX_W].
- Reset (rst_n low at clk edge):
  - All valid bits cleared, occupancy = 0, state = IDLE, kick counter = 0.
  - resp_valid = 0, resp_hit = 0, resp_status = 00, resp_table = 0, resp_index = 0, resp_key = 0.
  - op_ready = 0 while rst_n is low.
  - Reset mid-operation aborts it with no response; partial kicks are discarded along with the cleared table.
- IDLE: op_ready = 1. Accept on op_valid && op_ready; latch op_code and op_key; go to CHECK. op_ready = 0 in all other states, so op_valid is ignored while busy.
- CHECK (1 cycle): test T1[h1(key)] and T2[h2(key)] for valid && data == key. T1 takes priority if both match.
  - Lookup: go to RESP with resp_hit and location.
  - Delete: on a hit, clear that valid bit and decrement occupancy; go to RESP. A miss gives resp_hit = 0 and no change.
  - Insert, key present: go to RESP with hit = 1, status DUP, location of the existing copy; table unchanged.
  - Insert, key absent: cur = key, kicks = 0, go to PLACE1.
- PLACE1: slot s = T1[h1(cur)].
  - Empty: write cur, occupancy + 1, status OK, location (0, h1), go to RESP.
  - Occupied, kicks < MAX_KICKS: write cur into s; cur = old occupant; kicks + 1; go to PLACE2.
  - Occupied, kicks == MAX_KICKS: no write; status FAIL, resp_key = cur; go to RESP.
- PLACE2: same as PLACE1 but uses T2[h2(cur)] and reports location (1, h2). A swap returns to PLACE1.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Response fields hold their values until the next RESP.
  - Non-FAIL responses: resp_key = the command key.
  - There is no response back-pressure.
- Latency (accept edge to resp_valid):
  - Lookup and delete: 2 cycles.
  - Insert into an empty T1 slot: 3 cycles.
  - Each kick adds 1 cycle; worst case is 3 + MAX_KICKS.
- Occupancy changes only on a successful empty-slot write (+1) or a delete hit (-1); it never wraps. FAIL leaves occupancy unchanged.
- A MAX_KICKS = 0 insert fails immediately whenever T1[h1(key)] is occupied.

Test Plan (KEY_W=32, IDX_W=2, MAX_KICKS=4):
1. Reset, lookup 0x5 -> resp_valid 2 cycles after accept, hit = 0, occupancy = 0; op_ready = 0 during reset.
2. Insert 0x5 -> 3 cycles, OK, table 0, index 1, occupancy 1. Insert 0x5 again -> DUP, hit = 1, occupancy 1.
3. Insert 0x9 after 0x5 -> 4 cycles, OK, table 1, index 1 (0x5 evicted to T2[1]). Lookup 0x5 -> hit, table 1, index 1. Lookup 0x9 -> table 0, index 1.
4. Insert 0x00, 0x10, 0x20 -> third insert returns FAIL, resp_key = 0x10, latency 7. Final state T1[0] = 0x00, T2[0] = 0x20, occupancy 2.
5. Delete 0x9 -> hit, occupancy decrements. Delete 0x9 again -> miss. Lookup 0x9 -> miss. Toggling op_valid while busy has no effect.
6. Pull rst_n low during the kick loop of case 4 -> no resp_valid, occupancy 0, all lookups miss, op_ready = 1 the cycle after rst_n rises.
